// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// InstructionFetch
//   Fetch stage front end. Keeps the fetch PC, issues requests to a
//   zero-latency instruction memory and holds the last fetched word in an
//   output register until the control stage consumes it. Supports redirects
//   (branch/jump) and parks in a sticky fault state when redirected to a
//   target that is not word aligned.
//
// Parameters
//   WORDSIZE          address / data word width
//   INSTRUCTION_SIZE  instruction width
//   RESET_PC          first fetch address after reset
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous reset, active low
//   stall              in   control stage not accepting the current word
//   redirect_en        in   load redirect_pc as the next fetch address
//   redirect_pc        in   redirect target
//   im_req             out  instruction memory request
//   im_addr            out  instruction memory address (fetch PC)
//   im_ready           in   memory returns im_rdata this cycle
//   im_rdata           in   fetched instruction word
//   instruction        out  registered instruction to the control unit
//   instruction_valid  out  instruction holds a valid, unconsumed word
//   pc                 out  address of the word in instruction
//   misaligned_err     out  sticky misaligned-redirect flag
//   fetch_count        out  instructions accepted from memory since reset
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                    WORDSIZE         = 64,
  parameter int                    INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0]   RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        redirect_en,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        im_req,
  output logic [WORDSIZE-1:0]         im_addr,
  input  logic                        im_ready,
  input  logic [INSTRUCTION_SIZE-1:0] im_rdata,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic                        instruction_valid,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        misaligned_err,
  output logic [31:0]                 fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              r_state;
  logic [WORDSIZE-1:0] r_fetchPc;

  logic w_consume;
  logic w_imReq;
  logic w_fetchDone;
  logic w_misaligned;

  // Request decode. A request is only made while in FETCH and the output
  // register is either empty or being drained this cycle; gating with rst_n
  // keeps the request low for the whole reset interval.
  assign w_consume    = instruction_valid & ~stall;
  assign w_imReq      = rst_n & (r_state == FETCH) & (~instruction_valid | ~stall);
  assign w_fetchDone  = w_imReq & im_ready & ~redirect_en;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  assign im_req  = w_imReq;
  assign im_addr = r_fetchPc;

  // Main state machine and output register. A redirect overrides every
  // other event in FETCH and HOLD; FAULT only leaves through reset.
  // Leaving HOLD with stall low is itself a consumption, so the held word
  // is dropped and fetching restarts from the saved fetch PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= FETCH;
      r_fetchPc         <= RESET_PC;
      instruction       <= '0;
      pc                <= '0;
      instruction_valid <= 1'b0;
      misaligned_err    <= 1'b0;
      fetch_count       <= '0;
    end else begin
      case (r_state)
        FETCH, HOLD: begin
          if (redirect_en) begin
            r_fetchPc         <= redirect_pc;
            instruction_valid <= 1'b0;
            if (w_misaligned) begin
              r_state        <= FAULT;
              misaligned_err <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end else if (r_state == FETCH) begin
            if (w_fetchDone) begin
              instruction       <= im_rdata;
              pc                <= r_fetchPc;
              instruction_valid <= 1'b1;
              r_fetchPc         <= r_fetchPc + WORDSIZE'(4);
              fetch_count       <= fetch_count + 32'd1;
            end else if (w_consume) begin
              instruction_valid <= 1'b0;
            end
            if (instruction_valid && stall) begin
              r_state <= HOLD;
            end
          end else begin
            if (!stall) begin
              r_state           <= FETCH;
              instruction_valid <= 1'b0;
            end
          end
        end
        FAULT: begin
          instruction_valid <= 1'b0;
        end
        default: begin
          r_state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// TbInstructionFetch
//   Directed, self-checking bench for instruction_fetch. Inputs change on the
//   falling edge; combinational outputs are checked 1 time unit later and
//   registered outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        im_req;
  logic [63:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [63:0] pc;
  logic        misaligned_err;
  logic [31:0] fetch_count;

  int assertCount = 0;
  int failCount   = 0;

  instruction_fetch #(
    .WORDSIZE(64),
    .INSTRUCTION_SIZE(32),
    .RESET_PC(64'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .im_req(im_req),
    .im_addr(im_addr),
    .im_ready(im_ready),
    .im_rdata(im_rdata),
    .instruction(instruction),
    .instruction_valid(instruction_valid),
    .pc(pc),
    .misaligned_err(misaligned_err),
    .fetch_count(fetch_count)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive a full input vector on the falling edge, settle 1 unit
  task automatic applyStimulus(input logic st, input logic rdEn, input logic [63:0] rdPc,
                               input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    stall       = st;
    redirect_en = rdEn;
    redirect_pc = rdPc;
    im_ready    = rdy;
    im_rdata    = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered-output snapshot check
  task automatic checkRegs(input string tag, input logic valid, input logic [63:0] expPc,
                           input logic [31:0] expInstr, input logic [31:0] expCount,
                           input logic [63:0] expAddr);
    checkOutput({tag, ".valid"}, 64'(instruction_valid), 64'(valid));
    if (valid) begin
      checkOutput({tag, ".pc"}, pc, expPc);
      checkOutput({tag, ".instr"}, 64'(instruction), 64'(expInstr));
    end
    checkOutput({tag, ".count"}, 64'(fetch_count), 64'(expCount));
    checkOutput({tag, ".addr"}, im_addr, expAddr);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    im_ready    = 1'b0;
    im_rdata    = '0;

    // Reset state, also while clocks run under reset
    #2;
    checkOutput("rst.req", 64'(im_req), 64'd0);
    checkOutput("rst.addr", im_addr, 64'h0);
    checkOutput("rst.valid", 64'(instruction_valid), 64'd0);
    checkOutput("rst.err", 64'(misaligned_err), 64'd0);
    checkOutput("rst.count", 64'(fetch_count), 64'd0);
    tick();
    tick();
    checkOutput("rst.reqClk", 64'(im_req), 64'd0);

    // Streaming fetch of 0x13 words
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0013);
    checkOutput("run.req0", 64'(im_req), 64'd1);
    checkOutput("run.addr0", im_addr, 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkRegs("run", 1'b1, 64'(4 * k), 32'h13, 32'(k + 1), 64'(4 * k + 4));
      checkOutput("run.req", 64'(im_req), 64'd1);
    end

    // Stall three cycles with word at pc=8 held
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h0000_0055);
      checkOutput("stall.req", 64'(im_req), 64'd0);
      tick();
      checkRegs("stall", 1'b1, 64'h8, 32'h13, 32'd3, 64'hC);
    end
    // Release: held word consumed, then fetch resumes at 0xC
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0055);
    checkOutput("release.reqHold", 64'(im_req), 64'd0);
    tick();
    checkRegs("release", 1'b0, 64'h0, 32'h0, 32'd3, 64'hC);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0077);
    checkOutput("resume.req", 64'(im_req), 64'd1);
    tick();
    checkRegs("resume", 1'b1, 64'hC, 32'h77, 32'd4, 64'h10);

    // Memory not ready for two cycles
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'hDEAD_BEEF);
      checkOutput("wait.req", 64'(im_req), 64'd1);
      checkOutput("wait.addr", im_addr, 64'h10);
      tick();
      checkRegs("wait", 1'b0, 64'h0, 32'h0, 32'd4, 64'h10);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_00AA);
    tick();
    checkRegs("waitDone", 1'b1, 64'h10, 32'hAA, 32'd5, 64'h14);

    // Redirect to 0x100: word returned that cycle is discarded
    applyStimulus(1'b0, 1'b1, 64'h100, 1'b1, 32'h0000_00BB);
    tick();
    checkRegs("redir", 1'b0, 64'h0, 32'h0, 32'd5, 64'h100);
    checkOutput("redir.err", 64'(misaligned_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_00CC);
    checkOutput("redir.req", 64'(im_req), 64'd1);
    tick();
    checkRegs("redirFetch", 1'b1, 64'h100, 32'hCC, 32'd6, 64'h104);

    // Address wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h0000_0011);
    tick();
    checkRegs("wrapRedir", 1'b0, 64'h0, 32'h0, 32'd6, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_00DD);
    tick();
    checkRegs("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hDD, 32'd7, 64'h0);
    checkOutput("wrap.err", 64'(misaligned_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_00EE);
    tick();
    checkRegs("wrapNext", 1'b1, 64'h0, 32'hEE, 32'd8, 64'h4);

    // Misaligned redirect enters the sticky fault state
    applyStimulus(1'b0, 1'b1, 64'h102, 1'b1, 32'h0000_0099);
    tick();
    checkOutput("fault.err", 64'(misaligned_err), 64'd1);
    checkOutput("fault.req", 64'(im_req), 64'd0);
    checkRegs("fault", 1'b0, 64'h0, 32'h0, 32'd8, 64'h102);
    // Further inputs, including an aligned redirect, are ignored
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 64'h200, 1'b1, 32'h0000_0088);
      checkOutput("faultHold.req", 64'(im_req), 64'd0);
      tick();
      checkRegs("faultHold", 1'b0, 64'h0, 32'h0, 32'd8, 64'h102);
      checkOutput("faultHold.err", 64'(misaligned_err), 64'd1);
    end

    // Asynchronous reset pulse between edges
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h0000_0013);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.err", 64'(misaligned_err), 64'd0);
    checkOutput("arst.req", 64'(im_req), 64'd0);
    checkOutput("arst.addr", im_addr, 64'h0);
    checkOutput("arst.valid", 64'(instruction_valid), 64'd0);
    checkOutput("arst.count", 64'(fetch_count), 64'd0);
    checkOutput("arst.pc", pc, 64'h0);
    checkOutput("arst.instr", 64'(instruction), 64'h0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("restart.req", 64'(im_req), 64'd1);
    tick();
    checkRegs("restart", 1'b1, 64'h0, 32'h13, 32'd1, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL expose parameters, one per line:
- WORDSIZE, 64, data/address word width
- INSTRUCTION_SIZE, 32, instruction width
- RESET_PC, 0, first fetch address after reset
REQ-002 The block SHALL expose ports, one per line:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous reset, active low
- stall  input  1  downstream control stage not accepting the current instruction
- redirect_en  input  1  load redirect_pc as next fetch address (branch/jump)
- redirect_pc  input  WORDSIZE  redirect target
- im_req  output  1  instruction memory request
- im_addr  output  WORDSIZE  instruction memory address (= fetch_pc)
- im_ready  input  1  memory returns im_rdata this cycle for the current request
- im_rdata  input  INSTRUCTION_SIZE  fetched instruction word
- instruction  output  INSTRUCTION_SIZE  registered instruction to the control unit
- instruction_valid  output  1  instruction holds a valid, unconsumed word
- pc  output  WORDSIZE  address of the word in instruction
- misaligned_err  output  1  sticky fault flag
- fetch_count  output  32  instructions accepted from memory since reset
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low; no other clock or reset.

Function
REQ-004 The block SHALL hold internal register fetch_pc; im_addr SHALL equal fetch_pc combinationally.
REQ-005 The FSM SHALL have states FETCH, HOLD and FAULT.
REQ-006 The output register SHALL be consumed in any cycle with instruction_valid=1 and stall=0.
REQ-007 In FETCH, im_req SHALL be 1 when instruction_valid=0 or the output is consumed this cycle; otherwise 0.
REQ-008 A fetch SHALL complete on a cycle with im_req=1 and im_ready=1 and redirect_en=0.
REQ-009 On fetch completion, next edge: instruction<=im_rdata, pc<=fetch_pc, instruction_valid<=1, fetch_pc<=fetch_pc+4, fetch_count<=fetch_count+1 (zero-latency memory: one instruction per cycle sustained).
REQ-010 fetch_pc+4 and fetch_count+1 SHALL wrap modulo 2^WORDSIZE and 2^32 respectively, with no error.
REQ-011 Consumption without a fetch completion in the same cycle SHALL clear instruction_valid next edge.
REQ-012 FETCH->HOLD when instruction_valid=1 and stall=1 (no request issued); HOLD->FETCH when stall=0; in HOLD im_req=0 and instruction, pc, instruction_valid SHALL remain unchanged.
REQ-013 redirect_en=1 SHALL take priority over all other events: next edge fetch_pc<=redirect_pc, instruction_valid<=0, any im_rdata that cycle discarded, fetch_count unchanged, state<=FETCH; applies in FETCH and HOLD regardless of stall.
REQ-014 If redirect_en=1 and redirect_pc[1:0]!=2'b00, next edge state<=FAULT, misaligned_err<=1, instruction_valid<=0, fetch_pc<=redirect_pc.
REQ-015 In FAULT, im_req=0, instruction_valid=0, all inputs ignored; only rst_n exits.
REQ-016 im_ready while im_req=0 SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL immediately, independent of clk, set: fetch_pc=RESET_PC, instruction=0, pc=0, instruction_valid=0, misaligned_err=0, fetch_count=0, state=FETCH.
REQ-018 im_req SHALL be 0 while rst_n=0 and SHALL assert in the first cycle after rst_n rises.
REQ-019 Reset asserted mid-fetch or in HOLD/FAULT SHALL abandon all state with no partial update.

Verification
REQ-020 Bench SHALL cover:
- Reset release, im_ready=1 constant, stall=0, memory returns 0x0000_0013 words -> im_addr 0,4,8,..; instruction_valid=1 from 2nd edge; pc lags im_addr by one word; fetch_count increments each cycle.
- stall=1 for 3 cycles with a valid word at pc=8 -> im_req=0, instruction/pc frozen at pc=8 for 3 cycles; stall=0 -> fetch resumes at 0xC.
- im_ready=0 for 2 cycles -> im_req stays 1, im_addr constant, instruction_valid=0 after consumption; completes on 3rd cycle.
- redirect_en=1, redirect_pc=0x100 while im_ready=1 -> that word discarded, instruction_valid=0 next cycle, next im_addr=0x100, fetch_count unchanged.
- redirect_pc=0x102 -> misaligned_err=1, im_req=0 permanently; rst_n pulse low -> all outputs per REQ-017, fetch at RESET_PC.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC, fetch completes -> next im_addr=0, no fault.
